// File: rtl/i2c_seg_pkg.sv
// Shared types and constants for the I2C-controlled 7-segment display.
package i2c_seg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_t;

    localparam logic [7:0] CTRL_ADDR       = 8'hF0;
    localparam int         CTRL_DECODE_BIT = 0;
    localparam int         CTRL_ENABLE_BIT = 1;

    // Segments a..g in bits [6:0]
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/i2c_segment_display_if.sv
// I2C pad bundle: SCL/SDA pad inputs and the open-drain SDA pull-down enable.
interface i2c_segment_display_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_target_core.sv
// I2C target: pad synchronisers, START/STOP detection, byte FSM and register pointer.
module i2c_target_core
    import i2c_seg_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h2A
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_segment_display_if.slave  bus,
    output logic                  o_wr_en,
    output logic [7:0]            o_wr_addr,
    output logic [7:0]            o_wr_data,
    output logic [7:0]            o_rd_addr,
    input  logic [7:0]            i_rd_data
);

    i2c_state_t r_state, w_state_nxt;
    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_ptr, w_ptr_nxt;
    logic       r_sda_oe, w_oe_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_ack, w_ack_nxt;
    logic       w_wr_en;

    // Pads idle high, so the synchronisers reset high to avoid phantom edges
    wire w_scl_rise = r_scl_s2 & ~r_scl_d;
    wire w_scl_fall = ~r_scl_s2 & r_scl_d;
    wire w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    wire w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_ptr    <= 8'h00;
            r_sda_oe <= 1'b0;
            r_rw     <= 1'b0;
            r_ack    <= 1'b1;
        end else begin
            r_scl_s1 <= bus.scl_i; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
            r_sda_s1 <= bus.sda_i; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_sda_oe <= w_oe_nxt;
            r_rw     <= w_rw_nxt;
            r_ack    <= w_ack_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_oe_nxt    = r_sda_oe;
        w_rw_nxt    = r_rw;
        w_ack_nxt   = r_ack;
        w_wr_en     = 1'b0;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], r_sda_s2};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_oe_nxt  = 1'b1;
                        w_cnt_nxt = 4'd0;
                        case (r_state)
                            ST_ADDR: begin
                                if (r_shift[7:1] == I2C_ADDR) begin
                                    w_state_nxt = ST_ADDR_ACK;
                                    w_rw_nxt    = r_shift[0];
                                end else begin
                                    w_state_nxt = ST_IDLE;
                                    w_oe_nxt    = 1'b0;
                                end
                            end
                            ST_PTR: begin
                                w_ptr_nxt   = r_shift;
                                w_state_nxt = ST_PTR_ACK;
                            end
                            default: begin
                                w_wr_en     = 1'b1;
                                w_ptr_nxt   = r_ptr + 8'd1;
                                w_state_nxt = ST_WDATA_ACK;
                            end
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            w_state_nxt = ST_RDATA;
                            w_shift_nxt = i_rd_data;
                            w_oe_nxt    = ~i_rd_data[7];
                        end else begin
                            w_state_nxt = ST_PTR;
                            w_oe_nxt    = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt = ST_WDATA;
                        w_oe_nxt    = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_state_nxt = ST_RDATA_ACK;
                            w_oe_nxt    = 1'b0;
                            w_ptr_nxt   = r_ptr + 8'd1;
                        end else begin
                            w_oe_nxt = ~r_shift[7];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_ack_nxt = r_sda_s2;
                    end else if (w_scl_fall) begin
                        if (!r_ack) begin
                            w_state_nxt = ST_RDATA;
                            w_shift_nxt = i_rd_data;
                            w_oe_nxt    = ~i_rd_data[7];
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_oe_nxt    = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe = r_sda_oe;
    assign o_wr_en    = w_wr_en;
    assign o_wr_addr  = r_ptr;
    assign o_wr_data  = r_shift;
    assign o_rd_addr  = r_ptr;

endmodule

// File: rtl/i2c_segment_display.sv
// I2C-programmable multiplexed 7-segment display: register file, decoder and scan engine.
module i2c_segment_display
    import i2c_seg_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR   = 7'h2A,
    parameter int         NUM_DIGITS = 4,
    parameter int         SCAN_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_segment_display_if.slave  bus,
    output logic [7:0]            seg_o,
    output logic [NUM_DIGITS-1:0] dig_o
);

    localparam int         IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int         CNT_W     = $clog2(SCAN_DIV);
    localparam logic [7:0] NUM_DIG_B = 8'(NUM_DIGITS);

    logic                  w_wr_en;
    logic [7:0]            w_wr_addr, w_wr_data, w_rd_addr, w_rd_data;
    logic [7:0]            r_digit [NUM_DIGITS];
    logic [1:0]            r_ctrl;
    logic [CNT_W-1:0]      r_scan_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;

    function automatic logic [7:0] seg_value(input logic [7:0] v, input logic dec);
        return dec ? {v[7], HEX_SEG[v[3:0]]} : v;
    endfunction

    i2c_target_core #(.I2C_ADDR(I2C_ADDR)) u_core (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_wr_en   (w_wr_en),
        .o_wr_addr (w_wr_addr),
        .o_wr_data (w_wr_data),
        .o_rd_addr (w_rd_addr),
        .i_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 8'h00;
            r_ctrl <= 2'b00;
        end else if (w_wr_en) begin
            if (w_wr_addr < NUM_DIG_B)
                r_digit[w_wr_addr[IDX_W-1:0]] <= w_wr_data;
            else if (w_wr_addr == CTRL_ADDR)
                r_ctrl <= w_wr_data[1:0];
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (w_rd_addr < NUM_DIG_B)
            w_rd_data = r_digit[w_rd_addr[IDX_W-1:0]];
        else if (w_rd_addr == CTRL_ADDR)
            w_rd_data = {6'b0, r_ctrl};
    end

    // Slot counter keeps running while disabled so re-enabling resumes in phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= 8'h00;
            r_dig <= '0;
        end else if (r_ctrl[CTRL_ENABLE_BIT]) begin
            r_seg <= seg_value(r_digit[r_idx], r_ctrl[CTRL_DECODE_BIT]);
            r_dig <= NUM_DIGITS'(1) << r_idx;
        end else begin
            r_seg <= 8'h00;
            r_dig <= '0;
        end
    end

    assign seg_o = r_seg;
    assign dig_o = r_dig;

endmodule

// File: tb/tb_i2c_segment_display.sv
// Directed bench: bit-banged I2C master driving the display controller.
module tb_i2c_segment_display;
    import i2c_seg_pkg::*;

    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] seg_o;
    logic [3:0] dig_o;
    int         total = 0;
    int         bad = 0;
    int         oe_cnt = 0;

    i2c_segment_display_if bus_if ();
    assign bus_if.scl_i = scl_m;
    assign bus_if.sda_i = sda_m & ~bus_if.sda_oe;

    i2c_segment_display #(.I2C_ADDR(7'h2A), .NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if.slave),
        .seg_o (seg_o),
        .dig_o (dig_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (bus_if.sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b1; #(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; #(Q); scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); b = bus_if.sda_i; #(Q); scl_m = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic wr_reg(input logic [7:0] ptr, input logic [7:0] d, input string tag);
        logic a0, a1, a2;
        i2c_start;
        write_byte(8'h54, a0);
        write_byte(ptr, a1);
        write_byte(d, a2);
        i2c_stop;
        check(tag, {29'd0, a0, a1, a2}, 32'd0);
    endtask

    task automatic rd_check(input logic [7:0] ptr, input logic [7:0] exp, input string tag);
        logic       a;
        logic [7:0] d;
        i2c_start;
        write_byte(8'h54, a);
        write_byte(ptr, a);
        i2c_start;
        write_byte(8'h55, a);
        read_byte(1'b1, d);
        i2c_stop;
        check(tag, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic sync_digit0;
        for (int i = 0; i < 64 && dig_o == 4'b0001; i++) @(negedge clk);
        for (int i = 0; i < 64 && dig_o != 4'b0001; i++) @(negedge clk);
        check("dig_sync", {28'd0, dig_o}, 32'h1);
    endtask

    initial begin
        logic       a, a0, a1, a2, a3, a4;
        logic [7:0] d;
        logic [7:0] exp_seg [4];
        int         snap;
        exp_seg = '{8'h06, 8'h5B, 8'h4F, 8'h66};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_seg", {24'd0, seg_o}, 32'h0);
        check("rst_dig", {28'd0, dig_o}, 32'h0);
        check("rst_oe", {31'd0, bus_if.sda_oe}, 32'h0);
        check("rst_state", 32'(dut.u_core.r_state), 32'(ST_IDLE));

        // Read of DIGIT[0]=0x00 makes the target pull SDA low, then reset hits mid-byte
        i2c_start;
        write_byte(8'h55, a);
        check("rdreset_ack", {31'd0, a}, 32'h0);
        check("rdreset_oe_on", {31'd0, bus_if.sda_oe}, 32'h1);
        @(negedge clk); #2 rst = 1'b1;
        #1 check("rdreset_oe_async", {31'd0, bus_if.sda_oe}, 32'h0);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rdreset_seg", {24'd0, seg_o}, 32'h0);
        check("rdreset_dig", {28'd0, dig_o}, 32'h0);
        check("rdreset_oe", {31'd0, bus_if.sda_oe}, 32'h0);
        check("rdreset_state", 32'(dut.u_core.r_state), 32'(ST_IDLE));

        i2c_start;
        write_byte(8'h54, a0);
        write_byte(8'h00, a1);
        write_byte(8'h01, a2);
        write_byte(8'h02, a3);
        write_byte(8'h03, a4);
        write_byte(8'h04, a);
        i2c_stop;
        check("wr_acks", {26'd0, a0, a1, a2, a3, a4, a}, 32'h0);
        wr_reg(8'hF0, 8'h03, "ctrl_acks");

        sync_digit0;
        for (int i = 0; i < 16; i++) begin
            check("scan_dig", {28'd0, dig_o}, 32'h1 << ((i / 4) % 4));
            check("scan_seg", {24'd0, seg_o}, {24'd0, exp_seg[(i / 4) % 4]});
            @(negedge clk);
        end

        snap = oe_cnt;
        i2c_start;
        write_byte(8'h56, a);
        check("badaddr_nack", {31'd0, a}, 32'h1);
        write_byte(8'h00, a);
        write_byte(8'h99, a);
        i2c_stop;
        check("badaddr_no_oe", 32'(oe_cnt - snap), 32'h0);
        rd_check(8'h00, 8'h01, "badaddr_digit0");

        i2c_start;
        write_byte(8'h54, a0);
        write_byte(8'h01, a1);
        i2c_start;
        write_byte(8'h55, a2);
        check("rs_acks", {29'd0, a0, a1, a2}, 32'h0);
        read_byte(1'b0, d);
        check("rs_byte0", {24'd0, d}, 32'h02);
        read_byte(1'b0, d);
        check("rs_byte1", {24'd0, d}, 32'h03);
        read_byte(1'b1, d);
        check("rs_byte2", {24'd0, d}, 32'h04);
        check("rs_idle", 32'(dut.u_core.r_state), 32'(ST_IDLE));
        i2c_stop;

        rd_check(8'hF0, 8'h03, "rd_ctrl");
        rd_check(8'h10, 8'h00, "rd_unmapped");

        wr_reg(8'h00, 8'h80, "raw_wr_acks");
        wr_reg(8'hF0, 8'h02, "raw_ctrl_acks");
        sync_digit0;
        check("raw_seg", {24'd0, seg_o}, 32'h80);
        wr_reg(8'hF0, 8'h00, "off_ctrl_acks");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("off_dig", {28'd0, dig_o}, 32'h0);
            check("off_seg", {24'd0, seg_o}, 32'h0);
        end

        i2c_start;
        write_byte(8'h54, a0);
        write_byte(8'h00, a1);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        i2c_stop;
        check("partial_acks", {30'd0, a0, a1}, 32'h0);
        check("partial_idle", 32'(dut.u_core.r_state), 32'(ST_IDLE));
        rd_check(8'h00, 8'h80, "partial_discard");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_segment_display.md
# i2c_segment_display

Parametrised I2C-target 7-segment display controller with an arbitrary digit count. An on-chip I2C target (7-bit address) writes a small register file of per-digit values plus a control register; a scan engine time-multiplexes the digits onto one shared segment bus. It sits directly behind the chip top level: it takes the SCL/SDA pads as inputs, drives the open-drain SDA enable, and drives the segment/digit outputs.

## Interface
- `I2C_ADDR`, 7'h2A: 7-bit target address.
- `NUM_DIGITS`, 4: number of multiplexed digits, 1..8.
- `SCAN_DIV`, 1024: clk cycles per digit slot, ≥2.
- `clk` in 1: system clock; must be ≥20× SCL frequency.
- `rst` in 1: asynchronous, active-high reset.
- `scl_i` in 1: SCL pad input (asynchronous).
- `sda_i` in 1: SDA pad input (asynchronous).
- `sda_oe` out 1: 1 pulls SDA low (open-drain); 0 releases SDA.
- `seg_o` out 8: segments a..g in bits [6:0], decimal point in bit 7; active-high.
- `dig_o` out NUM_DIGITS: one-hot digit enable, active-high.

## Operation
- SCL/SDA pass through 2-FF synchronisers. Edges are detected on the synchronised values.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Register map (8-bit pointer):
  - 0x00..NUM_DIGITS-1: DIGIT[n].
  - 0xF0: CTRL. bit0 = DECODE (1: DIGIT[3:0] is hex-decoded and DIGIT[7] drives the DP; 0: DIGIT is driven raw onto seg_o). bit1 = ENABLE. Other bits read back as 0.
  - Writes to any other pointer value are ACKed and discarded. Reads from them return 0x00.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
  - IDLE –START→ ADDR.
  - ADDR: shift 8 bits, MSB first.
    - Address match → ADDR_ACK.
    - Mismatch → IDLE; sda_oe stays 0.
  - ADDR_ACK:
    - R/W=0 → PTR.
    - R/W=1 → RDATA, loaded with the register at the pointer.
  - PTR → PTR_ACK (pointer loaded) → WDATA.
  - WDATA → WDATA_ACK: commit the byte to the pointer, then pointer+1 (mod 256). Loop to WDATA.
  - RDATA: drive bits MSB first (sda_oe = ~bit) → RDATA_ACK. Sample the master's bit; the pointer advances after each byte sent.
    - ACK (0) → RDATA with the next byte.
    - NACK (1) → IDLE.
- STOP in any state → IDLE, with sda_oe released.
- START in any non-IDLE state (repeated start) → ADDR. The pointer is retained, so a write-pointer / repeated-start / read sequence works.
- Scan engine:
  - A counter runs 0..SCAN_DIV-1. At wrap, the digit index advances; it wraps from NUM_DIGITS-1 to 0.
  - ENABLE=0: dig_o=0 and seg_o=0. The counter keeps running.
  - seg_o reflects DIGIT[index] under the current DECODE setting.

## Timing
- Reset values:
  - sda_oe=0, seg_o=0, dig_o=0.
  - All DIGIT=0x00, CTRL=0x00 (display disabled).
  - Pointer=0, scan counter=0, index=0, FSM=IDLE.
- Reset assertion releases sda_oe asynchronously, including mid-transaction.
- Input latency: 2 clk (synchroniser) + 1 clk (edge detect) from a pad change to FSM action.
- sda_oe timing:
  - Changes 1 clk after a detected SCL falling edge.
  - Held until the next detected SCL falling edge.
  - Never changes while synchronised SCL is high.
- Register commit: on the SCL falling edge that ends the 8th data bit. The ACK is driven in the same cycle.
- Writes to the displayed digit or to CTRL: seg_o/dig_o follow 1 clk after the commit. They are registered outputs.
- Digit switch: dig_o and seg_o update in the same clk. dig_o is never multi-hot.
- Master data changes while SCL is high are interpreted as START/STOP by design.

## Structure
- Shared package `i2c_seg_pkg`:
  - FSM state enum.
  - CTRL_ADDR (8'hF0), CTRL bit indices.
  - 16-entry hex→segment constant table.
- One sub-module, `i2c_target_core`: synchroniser, START/STOP detection, byte FSM, pointer. It exposes a write strobe/address/data and a read address/data to the top.
- The register file, decoder and scan engine live in the top module.

## Test plan
- Reset mid-read, with sda_oe=1 → sda_oe=0 immediately. All outputs are 0 and the FSM is IDLE after release.
- Write to 0x2A: pointer 0x00, data 0x01,0x02,0x03,0x04, then pointer 0xF0, data 0x03. Required: every byte ACKed. With NUM_DIGITS=4, SCAN_DIV=4, dig_o cycles 0001→0010→0100→1000→0001 every 4 clk, and seg_o=0x06, 0x5B, 0x4F, 0x66 respectively.
- Address 0x2B write → no ACK (sda_oe stays 0) and no register change.
- Set pointer 0x01, repeated START, read 3 bytes (ACK, ACK, NACK) → returns 0x02, 0x03, 0x04 and the FSM returns to IDLE.
- CTRL=0x02 with DIGIT[0]=0x80 → seg_o=0x80 when digit 0 is active. CTRL=0x00 → dig_o=0, seg_o=0.
- STOP mid-byte during WDATA → the partial byte is discarded and the register is unchanged.
